// File: rtl/simon_controller.sv
// Simon game control FSM: sequences input, playback, repeat and done phases,
// issues datapath strobes and paces playback/replay with a tick timer.
module simon_controller #(
  parameter int PLAY_TICKS = 4,
  parameter int MAX_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       next,
  input  logic       input_valid,
  input  logic       rw_eq,
  input  logic       input_eq_pat,
  output logic [1:0] st,
  output logic       mux_control,
  output logic       w_en,
  output logic       increase,
  output logic       adv,
  output logic       done,
  output logic       clear,
  output logic [3:0] mode_leds,
  output logic       win
);

  localparam int TW = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(PLAY_TICKS - 1);
  localparam logic [LW-1:0] LEN_LAST  = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_INIT,
    S_INPUT,
    S_PLAYBACK,
    S_REPEAT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   len_q, len_d;
  logic            next_q;
  logic            win_q, win_d;

  logic            nxt;
  logic            tick;
  logic            w_en_c, inc_c, adv_c, done_c;

  // One pulse per button press; a held button is seen only on its rising edge.
  assign nxt  = next & ~next_q;
  assign tick = (timer_q == TICK_LAST);

  // State, timer, length, button history and win flag registers.
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous (sampled on the edge), and sequential
    // state always uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      state_q <= S_INIT;
      timer_q <= '0;
      len_q   <= '0;
      next_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      next_q  <= next;
      win_q   <= win_d;
    end
  end

  // Next-state, timer/length updates and phase-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    timer_d     = '0;          // cleared whenever not pacing, so each entry starts at 0
    len_d       = len_q;
    win_d       = win_q;
    st          = 2'b00;
    mux_control = 1'b0;
    mode_leds   = 4'b0000;
    clear       = 1'b0;
    w_en_c      = 1'b0;
    inc_c       = 1'b0;
    adv_c       = 1'b0;
    done_c      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        clear   = 1'b1;
        state_d = S_INPUT;
      end

      S_INPUT: begin
        mode_leds = 4'b0001;
        if (nxt && input_valid) begin
          w_en_c = 1'b1;
          inc_c  = 1'b1;
          if (len_q != LEN_MAX) len_d = len_q + LW'(1);
          if (len_q == LEN_LAST) begin
            state_d = S_DONE;
            win_d   = 1'b1;
          end else begin
            state_d = S_PLAYBACK;
          end
        end
      end

      S_PLAYBACK: begin
        st          = 2'b01;
        mux_control = 1'b1;
        mode_leds   = 4'b0010;
        timer_d     = tick ? '0 : timer_q + TW'(1);
        if (tick) begin
          if (rw_eq) begin
            done_c  = 1'b1;
            state_d = S_REPEAT;
          end else begin
            adv_c = 1'b1;
          end
        end
      end

      S_REPEAT: begin
        st        = 2'b10;
        mode_leds = 4'b0100;
        if (nxt) begin
          if (!input_eq_pat) begin
            done_c  = 1'b1;
            win_d   = 1'b0;
            state_d = S_DONE;
          end else if (rw_eq) begin
            done_c  = 1'b1;
            state_d = S_INPUT;
          end else begin
            adv_c = 1'b1;
          end
        end
      end

      S_DONE: begin
        st          = 2'b11;
        mux_control = 1'b1;
        mode_leds   = 4'b1000;
        timer_d     = tick ? '0 : timer_q + TW'(1);
        if (tick) begin
          if (rw_eq) done_c = 1'b1;
          else       adv_c  = 1'b1;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // Reset held low suppresses every datapath strobe in that cycle.
  assign w_en     = w_en_c & rst_n;
  assign increase = inc_c  & rst_n;
  assign adv      = adv_c  & rst_n;
  assign done     = done_c & rst_n;
  assign win      = win_q;

endmodule

// File: tb/tb_simon_controller.sv
// Directed bench for simon_controller: the stimulus process queues the
// expected output vector for each driven cycle, a monitor pops and compares.
module tb_simon_controller;

  localparam int PLAY_TICKS = 4;
  localparam int MAX_LEN    = 4;

  logic       clk = 1'b0;
  logic       rst_n, next, input_valid, rw_eq, input_eq_pat;
  logic [1:0] st;
  logic       mux_control, w_en, increase, adv, done, clear, win;
  logic [3:0] mode_leds;

  simon_controller #(.PLAY_TICKS(PLAY_TICKS), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next         (next),
    .input_valid  (input_valid),
    .rw_eq        (rw_eq),
    .input_eq_pat (input_eq_pat),
    .st           (st),
    .mux_control  (mux_control),
    .w_en         (w_en),
    .increase     (increase),
    .adv          (adv),
    .done         (done),
    .clear        (clear),
    .mode_leds    (mode_leds),
    .win          (win)
  );

  always #5 clk = ~clk;

  typedef enum {P_INIT, P_IN, P_PB, P_RP, P_DN} ph_e;

  typedef struct {
    int          step;
    logic [12:0] v;   // {st, mux, w_en, increase, adv, done, clear, mode_leds, win}
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step     = 0;

  // Strobe patterns {w_en, increase, adv, done, clear}
  localparam logic [4:0] N  = 5'b00000;
  localparam logic [4:0] WR = 5'b11000;
  localparam logic [4:0] AD = 5'b00100;
  localparam logic [4:0] DN = 5'b00010;
  localparam logic [4:0] CL = 5'b00001;

  // Phase -> {st, mux_control, mode_leds}
  function automatic logic [6:0] phase_bits(input ph_e p);
    case (p)
      P_INIT:  return 7'b00_0_0000;
      P_IN:    return 7'b00_0_0001;
      P_PB:    return 7'b01_1_0010;
      P_RP:    return 7'b10_0_0100;
      default: return 7'b11_1_1000;
    endcase
  endfunction

  // Drive one cycle and queue the expected outputs for it.
  task automatic cyc(input logic r, input logic nx, input logic iv, input logic rw,
                     input logic eq, input ph_e p, input logic [4:0] s, input logic w);
    logic [6:0] pb;
    exp_t e;
    @(posedge clk); #1;
    rst_n = r; next = nx; input_valid = iv; rw_eq = rw; input_eq_pat = eq;
    pb     = phase_bits(p);
    step   = step + 1;
    e.step = step;
    e.v    = {pb[6:5], pb[4], s, pb[3:0], w};
    exp_q.push_back(e);
  endtask

  // Reset cycle with no expectation queued.
  task automatic rst_cyc();
    @(posedge clk); #1;
    rst_n = 1'b0; next = 1'b0; input_valid = 1'b0; rw_eq = 1'b0; input_eq_pat = 1'b0;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      if ({st, mux_control, w_en, increase, adv, done, clear, mode_leds, win} == cur.v)
        n_pass++;
      else
        $display("FAIL step %0d outputs: got %b expected %b", cur.step,
                 {st, mux_control, w_en, increase, adv, done, clear, mode_leds, win}, cur.v);
    end
  end

  initial begin
    rst_n = 1'b0; next = 1'b0; input_valid = 1'b0; rw_eq = 1'b0; input_eq_pat = 1'b0;
    repeat (2) rst_cyc();

    // 1. Reset release: clear for exactly one cycle, then INPUT idle
    cyc(1, 0, 0, 0, 0, P_INIT, CL, 0);
    cyc(1, 0, 0, 0, 0, P_IN,   N,  0);

    // 2. Round 1 write, playback of len 1: done on the 4th playback cycle
    cyc(1, 1, 1, 0, 0, P_IN, WR, 0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, DN, 0);
    cyc(1, 0, 0, 0, 0, P_RP, N,  0);
    cyc(1, 1, 0, 1, 1, P_RP, DN, 0);   // round passed
    cyc(1, 0, 0, 0, 0, P_IN, N,  0);

    // 3. Round 2 (len 2): adv then done in playback, press ignored in playback
    cyc(1, 1, 1, 0, 0, P_IN, WR, 0);
    cyc(1, 0, 0, 0, 0, P_PB, N,  0);
    cyc(1, 1, 0, 0, 0, P_PB, N,  0);
    cyc(1, 0, 0, 0, 0, P_PB, N,  0);
    cyc(1, 0, 0, 0, 0, P_PB, AD, 0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, DN, 0);
    cyc(1, 1, 0, 0, 1, P_RP, AD, 0);
    cyc(1, 0, 0, 0, 1, P_RP, N,  0);
    cyc(1, 1, 0, 1, 1, P_RP, DN, 0);
    cyc(1, 0, 0, 0, 0, P_IN, N,  0);

    // 4. Round 3 then a wrong repeat: lost, DONE replays, presses give no w_en
    cyc(1, 1, 1, 0, 0, P_IN, WR, 0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, N,  0);
    cyc(1, 0, 0, 1, 0, P_PB, DN, 0);
    cyc(1, 1, 1, 0, 0, P_RP, DN, 0);
    cyc(1, 0, 1, 0, 0, P_DN, N,  0);
    cyc(1, 1, 1, 0, 0, P_DN, N,  0);
    cyc(1, 0, 1, 0, 0, P_DN, N,  0);
    cyc(1, 0, 1, 0, 0, P_DN, AD, 0);
    cyc(1, 0, 0, 1, 0, P_DN, N,  0);
    cyc(1, 1, 1, 1, 0, P_DN, N,  0);
    cyc(1, 0, 0, 1, 0, P_DN, N,  0);
    cyc(1, 0, 0, 1, 0, P_DN, DN, 0);

    // 5. New game: invalid press, then a button held for 10 cycles
    repeat (2) rst_cyc();
    cyc(1, 0, 0, 0, 0, P_INIT, CL, 0);
    cyc(1, 0, 0, 0, 0, P_IN,   N,  0);
    cyc(1, 1, 0, 0, 0, P_IN,   N,  0);
    cyc(1, 0, 0, 0, 0, P_IN,   N,  0);
    cyc(1, 1, 1, 0, 0, P_IN,   WR, 0);
    cyc(1, 1, 1, 1, 0, P_PB,   N,  0);
    cyc(1, 1, 1, 1, 0, P_PB,   N,  0);
    cyc(1, 1, 1, 1, 0, P_PB,   N,  0);
    cyc(1, 1, 1, 1, 0, P_PB,   DN, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 1, P_RP, N, 0);
    cyc(1, 0, 1, 1, 1, P_RP, N,  0);
    cyc(1, 1, 0, 1, 1, P_RP, DN, 0);

    // 6. Capacity: writes 2 and 3 as normal rounds, the 4th write wins
    for (int r = 0; r < 2; r++) begin
      cyc(1, 0, 0, 0, 0, P_IN, N,  0);
      cyc(1, 1, 1, 0, 0, P_IN, WR, 0);
      cyc(1, 0, 0, 1, 0, P_PB, N,  0);
      cyc(1, 0, 0, 1, 0, P_PB, N,  0);
      cyc(1, 0, 0, 1, 0, P_PB, N,  0);
      cyc(1, 0, 0, 1, 0, P_PB, DN, 0);
      cyc(1, 0, 0, 0, 0, P_RP, N,  0);
      cyc(1, 1, 0, 1, 1, P_RP, DN, 0);
    end
    cyc(1, 0, 0, 0, 0, P_IN, N,  0);
    cyc(1, 1, 1, 0, 0, P_IN, WR, 0);
    cyc(1, 0, 0, 0, 0, P_DN, N,  1);
    cyc(1, 0, 0, 0, 0, P_DN, N,  1);
    cyc(1, 0, 0, 0, 0, P_DN, N,  1);
    cyc(1, 0, 0, 1, 0, P_DN, DN, 1);
    cyc(1, 0, 0, 0, 0, P_DN, N,  1);

    // Reset from DONE clears win; then reset mid-playback at a would-be done
    rst_cyc();
    cyc(1, 0, 0, 0, 0, P_INIT, CL, 0);
    cyc(1, 0, 0, 0, 0, P_IN,   N,  0);
    cyc(1, 1, 1, 0, 0, P_IN,   WR, 0);
    cyc(1, 0, 0, 1, 0, P_PB,   N,  0);
    cyc(1, 0, 0, 1, 0, P_PB,   N,  0);
    cyc(1, 0, 0, 1, 0, P_PB,   N,  0);
    cyc(0, 0, 0, 1, 0, P_PB,   N,  0);   // reset low suppresses the done strobe
    cyc(1, 0, 0, 1, 0, P_INIT, CL, 0);
    cyc(1, 0, 0, 1, 0, P_IN,   N,  0);

    // Let the monitor drain; any leftover expectation is a failure
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
